uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, baud_tick pulses per bit period.
REQ-002 SHALL have ports, one per line:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-clk pulse from baud_generator (baud_clk), OVERSAMPLE per bit.
- wls  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
- stb  input  1  0 = 1 stop bit, 1 = 2 stop bits.
- pen  input  1  parity enable.
- eps  input  1  1 = even parity, 0 = odd parity.
- brk  input  1  break control; forces txd low.
- tx_data  input  8  character to send, LSB first; unused upper bits ignored.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  holding register empty (THRE).
- tx_empty  output  1  holding register and shifter both idle (TEMT).
- txd  output  1  serial line, idle high.
REQ-003 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 SHALL transfer a character into the holding register on any clk edge where tx_valid and tx_ready are both 1.
REQ-005 tx_ready SHALL drop the cycle after the transfer and rise the cycle after the shifter takes the character.
REQ-006 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-007 In IDLE with the holding register full, the first baud_tick SHALL:
- load the shifter;
- latch wls, stb, pen and eps for the whole frame;
- free the holding register;
- enter START.
REQ-008 Each START, DATA, PARITY or STOP bit SHALL hold txd for exactly OVERSAMPLE baud_ticks, counted by a log2(OVERSAMPLE)-bit tick counter.
REQ-009 txd levels SHALL be: START = 0; DATA = data bits LSB first, count per the latched wls; PARITY = even/odd parity of the data bits.
REQ-010 PARITY SHALL be skipped when pen = 0.
REQ-011 STOP SHALL drive txd = 1 for 1 bit (stb = 0) or 2 bits (stb = 1).
REQ-012 At the end of STOP, a full holding register SHALL load the shifter on that same tick and go directly to START, with no idle bit; otherwise the FSM SHALL go to IDLE.
REQ-013 Without baud_tick pulses, all state and counters SHALL hold their values.
REQ-014 brk = 1 SHALL force txd = 0 without changing FSM or counter progress.
REQ-015 tx_empty SHALL equal 1 only in IDLE with the holding register empty.
REQ-016 A tx_valid pulse while tx_ready = 0 SHALL be ignored; no overwrite occurs.

Reset
REQ-017 rst SHALL, on a clk edge, set: FSM = IDLE, counters = 0, holding register empty, txd = 1, tx_ready = 1, tx_empty = 1.
REQ-018 rst asserted mid-frame SHALL abort the frame; txd SHALL be 1 the cycle after that edge.

Structure
REQ-019 A shared uart_pkg SHALL hold:
- the tx state enum;
- the wls encoding constants;
- the default OVERSAMPLE value.
REQ-020 uart_tx SHALL be a single module with no sub-module; parity SHALL be computed inline by XOR reduction.

Verification
REQ-021 All scenarios SHALL use baud_tick every 4 clk and OVERSAMPLE = 16.
REQ-022 8N1, tx_data 0xA5 -> txd bits 0,1,0,1,0,0,1,0,1,1, each 64 clk; tx_empty returns to 1 after the stop bit.
REQ-023 7E1, 0x41 -> start 0; data 1,0,0,0,0,0,1; parity 0; stop 1. 5O2, 0x1F -> data 1,1,1,1,1; parity 0; two stop bits, 128 clk total high.
REQ-024 Back-to-back: 0x55 then 0xAA, second offered while the first shifts -> the second start bit directly follows the first stop bit, no gap. tx_ready falls after the first accept and again after the second.
REQ-025 rst asserted in DATA bit 3 -> txd = 1, tx_ready = 1, tx_empty = 1 the next cycle. A new 0x0F afterward transmits correctly.
REQ-026 brk = 1 mid-frame -> txd = 0 throughout brk; frame timing is unchanged. A third tx_valid while tx_ready = 0 is dropped.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, word-length codes and
// the default oversample ratio.
// Holds no logic; imported by uart_tx.
package uart_pkg;

    // baud_tick pulses per serial bit period
    localparam int UART_OVERSAMPLE_DEFAULT = 16;

    // wls encoding (line control register word length select)
    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // Index of the last data bit for a word length code (5 bits -> 4 ... 8 bits -> 7)
    function automatic logic [2:0] last_data_bit(input logic [1:0] wls);
        return {1'b0, wls} + 3'd4;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register (THR) feeding a frame shifter.
// Latency: a character accepted on clk edge N starts its start bit at the first
//          baud_tick after N; each line bit lasts OVERSAMPLE baud_ticks.
// Backpressure: tx_ready is low while the holding register is full; tx_valid
//          offered while tx_ready is low is dropped, the held character is kept.
// Ports: clk/rst (sync, active-high), baud_tick (oversample strobe),
//        wls/stb/pen/eps/brk (line control), tx_data/tx_valid/tx_ready (THR
//        write handshake), tx_empty (THR and shifter idle), txd (serial line).
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic [1:0] wls,
    input  logic       stb,
    input  logic       pen,
    input  logic       eps,
    input  logic       brk,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_empty,
    output logic       txd
);

    localparam int              CW        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0]   TICK_LAST = CW'(OVERSAMPLE - 1);

    tx_state_e     state_q,     state_d;
    logic [CW-1:0] tick_cnt_q,  tick_cnt_d;
    logic [2:0]    bit_cnt_q,   bit_cnt_d;   // data bit index, or stop bit index
    logic [7:0]    shift_q,     shift_d;
    logic [1:0]    wls_q,       wls_d;
    logic          stb_q,       stb_d;
    logic          pen_q,       pen_d;
    logic          eps_q,       eps_d;
    logic [7:0]    hold_dat_q,  hold_dat_d;
    logic          hold_full_q, hold_full_d;

    logic          bit_end;
    logic          load;
    logic [7:0]    data_mask;
    logic          line_bit;

    // Last tick of the current line bit; the counter never runs in IDLE.
    assign bit_end   = baud_tick && (state_q != TX_IDLE) && (tick_cnt_q == TICK_LAST);
    assign data_mask = 8'hFF >> (2'd3 - wls_q);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        wls_d       = wls_q;
        stb_d       = stb_q;
        pen_d       = pen_q;
        eps_d       = eps_q;
        hold_dat_d  = hold_dat_q;
        hold_full_d = hold_full_q;
        load        = 1'b0;

        // Holding register write; never overwrites a full register.
        if (tx_valid && !hold_full_q) begin
            hold_dat_d  = tx_data;
            hold_full_d = 1'b1;
        end

        if (baud_tick && (state_q != TX_IDLE)) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + CW'(1);
        end

        if (baud_tick && (state_q == TX_IDLE) && hold_full_q) begin
            load = 1'b1;
        end

        if (bit_end) begin
            case (state_q)
                TX_START: begin
                    state_d   = TX_DATA;
                    bit_cnt_d = 3'd0;
                end
                TX_DATA: begin
                    if (bit_cnt_q == last_data_bit(wls_q)) begin
                        state_d   = pen_q ? TX_PARITY : TX_STOP;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                TX_PARITY: begin
                    state_d   = TX_STOP;
                    bit_cnt_d = 3'd0;
                end
                TX_STOP: begin
                    if (stb_q && (bit_cnt_q == 3'd0)) begin
                        bit_cnt_d = 3'd1;
                    end else if (hold_full_q) begin
                        // Chain the next frame with no idle bit in between.
                        load = 1'b1;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
                default: state_d = TX_IDLE;
            endcase
        end

        // Line control is frozen per frame so mid-frame LCR writes cannot corrupt it.
        if (load) begin
            shift_d     = hold_dat_q;
            wls_d       = wls;
            stb_d       = stb;
            pen_d       = pen;
            eps_d       = eps;
            hold_full_d = 1'b0;
            state_d     = TX_START;
            tick_cnt_d  = '0;
            bit_cnt_d   = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= TX_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            wls_q       <= WLS_8;
            stb_q       <= 1'b0;
            pen_q       <= 1'b0;
            eps_q       <= 1'b0;
            hold_dat_q  <= 8'h00;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            wls_q       <= wls_d;
            stb_q       <= stb_d;
            pen_q       <= pen_d;
            eps_q       <= eps_d;
            hold_dat_q  <= hold_dat_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Line level derived from registered state; parity is taken over the
    // masked data so unused upper bits never contribute.
    always_comb begin
        line_bit = 1'b1;
        case (state_q)
            TX_START:  line_bit = 1'b0;
            TX_DATA:   line_bit = shift_q[bit_cnt_q];
            TX_PARITY: line_bit = (^(shift_q & data_mask)) ^ ~eps_q;
            default:   line_bit = 1'b1;
        endcase
    end

    // Break only masks the line; the frame keeps running underneath.
    assign txd      = line_bit & ~brk;
    assign tx_ready = ~hold_full_q;
    assign tx_empty = (state_q == TX_IDLE) && !hold_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: baud_tick every 4 clk, OVERSAMPLE 16 (64 clk per bit).
// Expected line waveforms come from a frame model built from data and line settings.
// Each line bit is checked over all 64 of its clk samples.
module tb_uart_tx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       brk;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_empty;
    logic       txd;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    uart_tx #(.OVERSAMPLE(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_tick(baud_tick),
        .wls      (wls),
        .stb      (stb),
        .pen      (pen),
        .eps      (eps),
        .brk      (brk),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_empty (tx_empty),
        .txd      (txd)
    );

    always #5 clk = ~clk;

    // One baud_tick every 4 clk, driven away from the sampling edge.
    initial begin
        logic [1:0] div;
        div       = 2'd0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            div       = div + 2'd1;
            baud_tick = (div == 2'd0);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference frame: start, word-length data bits LSB first, optional parity
    // making the count of ones even (eps=1) or odd (eps=0), then 1 or 2 stop bits.
    task automatic add_frame(input logic [7:0] d, input logic [1:0] w,
                             input logic s, input logic p, input logic e);
        int n;
        int ones;
        n    = 5 + int'(w);
        ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (p) exp_q.push_back(e ? (ones % 2 == 1) : (ones % 2 == 0));
        exp_q.push_back(1'b1);
        if (s) exp_q.push_back(1'b1);
    endtask

    task automatic set_cfg(input logic [1:0] w, input logic s, input logic p, input logic e);
        wls = w; stb = s; pen = p; eps = e;
    endtask

    task automatic send_char(input logic [7:0] d, input string name);
        int t;
        for (t = 0; t < 3000 && tx_ready !== 1'b1; t++) @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: tx_ready=%b required 1", name, tx_ready);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_drop: tx_ready=%b required 0", name, tx_ready);
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            #1;
            if (txd === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Compares txd against exp_q from the first falling edge on; brk is held
    // over samples [bf, bt) and the expected line is 0 there.
    task automatic capture(input string name, input int bf, input int bt, input bit chk_empty);
        bit   ok;
        int   nb;
        int   bad;
        logic expv;
        nb  = exp_q.size();
        bad = 0;
        wait_start(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s start: no start bit seen, txd=%b required 0", name, txd);
            return;
        end
        for (int s = 0; s < nb * 64; s++) begin
            if (s > 0) begin
                @(negedge clk);
                brk = (s >= bf && s < bt);
                #1;
            end
            expv = brk ? 1'b0 : exp_q[s / 64];
            if (txd !== expv) bad++;
            if (s % 64 == 63) begin
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL %s bit%0d: %0d samples wrong, last txd=%b required %b",
                             name, s / 64, bad, txd, expv);
                end
                bad = 0;
            end
        end
        brk = 1'b0;
        if (chk_empty) begin
            @(negedge clk);
            #1;
            checks++;
            if (tx_empty !== 1'b1) begin
                errors++;
                $display("FAIL %s empty_after_stop: tx_empty=%b required 1", name, tx_empty);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_valid = 1'b0; brk = 1'b0; tx_data = 8'h00;
        set_cfg(WLS_8, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        checks += 3;
        if (txd !== 1'b1)      begin errors++; $display("FAIL reset txd: %b required 1", txd); end
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset tx_ready: %b required 1", tx_ready); end
        if (tx_empty !== 1'b1) begin errors++; $display("FAIL reset tx_empty: %b required 1", tx_empty); end
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (txd !== 1'b1 || tx_empty !== 1'b1) begin
            errors++;
            $display("FAIL idle_line: txd=%b tx_empty=%b required 1 1", txd, tx_empty);
        end
    endtask

    task automatic test_formats();
        set_cfg(WLS_8, 1'b0, 1'b0, 1'b0);
        exp_q.delete(); add_frame(8'hA5, WLS_8, 1'b0, 1'b0, 1'b0);
        send_char(8'hA5, "8n1");
        capture("8n1", 0, 0, 1'b1);

        set_cfg(WLS_7, 1'b0, 1'b1, 1'b1);
        exp_q.delete(); add_frame(8'h41, WLS_7, 1'b0, 1'b1, 1'b1);
        send_char(8'h41, "7e1");
        capture("7e1", 0, 0, 1'b1);

        set_cfg(WLS_5, 1'b1, 1'b1, 1'b0);
        exp_q.delete(); add_frame(8'h1F, WLS_5, 1'b1, 1'b1, 1'b0);
        send_char(8'h1F, "5o2");
        capture("5o2", 0, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        set_cfg(WLS_8, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
        add_frame(8'h55, WLS_8, 1'b0, 1'b0, 1'b0);
        add_frame(8'hAA, WLS_8, 1'b0, 1'b0, 1'b0);
        fork
            begin
                send_char(8'h55, "b2b_first");
                send_char(8'hAA, "b2b_second");
            end
            capture("b2b", 0, 0, 1'b1);
        join
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_cfg(WLS_8, 1'b0, 1'b0, 1'b0);
        send_char(8'hF0, "rst_mid");   // data bit 3 is 0, so the line is low before reset
        wait_start(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_mid start: txd=%b required 0", txd); end
        send_char(8'h33, "rst_mid_hold");
        repeat (275 - 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks += 3;
        if (txd !== 1'b1)      begin errors++; $display("FAIL rst_mid txd: %b required 1", txd); end
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_mid tx_ready: %b required 1", tx_ready); end
        if (tx_empty !== 1'b1) begin errors++; $display("FAIL rst_mid tx_empty: %b required 1", tx_empty); end
        rst = 1'b0;
        exp_q.delete(); add_frame(8'h0F, WLS_8, 1'b0, 1'b0, 1'b0);
        send_char(8'h0F, "after_rst");
        capture("after_rst", 0, 0, 1'b1);
    endtask

    task automatic test_brk_and_drop();
        int bad;
        set_cfg(WLS_8, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
        add_frame(8'h3C, WLS_8, 1'b0, 1'b0, 1'b0);
        add_frame(8'hC3, WLS_8, 1'b0, 1'b0, 1'b0);
        fork
            begin
                send_char(8'h3C, "brk_x");
                send_char(8'hC3, "brk_y");
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                checks++;
                if (tx_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_ready: tx_ready=%b required 0", tx_ready);
                end
            end
            capture("brk", 100, 300, 1'b1);
        join
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (txd !== 1'b1 || tx_empty !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL drop_no_third_frame: %0d non-idle samples, required 0", bad);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [1:0] w;
        logic       s, p, e;
        for (int n = 0; n < 4; n++) begin
            d = 8'($urandom);
            w = 2'($urandom_range(3, 0));
            s = 1'($urandom);
            p = 1'($urandom);
            e = 1'($urandom);
            set_cfg(w, s, p, e);
            exp_q.delete(); add_frame(d, w, s, p, e);
            send_char(d, $sformatf("rand%0d", n));
            capture($sformatf("rand%0d d=%h w=%0d s=%0d p=%0d e=%0d", n, d, w, s, p, e),
                    0, 0, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_reset_mid();
        test_brk_and_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
